// File: rtl/kc_sched_pkg.sv
// Shared types and the HID keymap for the keycode event scheduler.
// lookup() turns a HID usage code into {hit, player, action}.
package kc_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT
    } state_t;

    typedef enum logic [2:0] {
        ACT_UP    = 3'd0,
        ACT_DOWN  = 3'd1,
        ACT_LEFT  = 3'd2,
        ACT_RIGHT = 3'd3,
        ACT_PUNCH = 3'd4,
        ACT_KICK  = 3'd5,
        ACT_BLOCK = 3'd6
    } action_t;

    typedef struct packed {
        logic    hit;
        logic    player;
        action_t action;
    } map_t;

    localparam logic [7:0] KEY_P0_UP    = 8'h1A;
    localparam logic [7:0] KEY_P0_DOWN  = 8'h16;
    localparam logic [7:0] KEY_P0_LEFT  = 8'h04;
    localparam logic [7:0] KEY_P0_RIGHT = 8'h07;
    localparam logic [7:0] KEY_P0_PUNCH = 8'h09;
    localparam logic [7:0] KEY_P0_KICK  = 8'h0A;
    localparam logic [7:0] KEY_P0_BLOCK = 8'h0B;
    localparam logic [7:0] KEY_P1_UP    = 8'h52;
    localparam logic [7:0] KEY_P1_DOWN  = 8'h51;
    localparam logic [7:0] KEY_P1_LEFT  = 8'h50;
    localparam logic [7:0] KEY_P1_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_P1_PUNCH = 8'h0E;
    localparam logic [7:0] KEY_P1_KICK  = 8'h0F;
    localparam logic [7:0] KEY_P1_BLOCK = 8'h33;

    function automatic map_t lookup(input logic [7:0] code);
        map_t m;
        m = '{hit: 1'b1, player: 1'b0, action: ACT_UP};
        case (code)
            KEY_P0_UP:    m.action = ACT_UP;
            KEY_P0_DOWN:  m.action = ACT_DOWN;
            KEY_P0_LEFT:  m.action = ACT_LEFT;
            KEY_P0_RIGHT: m.action = ACT_RIGHT;
            KEY_P0_PUNCH: m.action = ACT_PUNCH;
            KEY_P0_KICK:  m.action = ACT_KICK;
            KEY_P0_BLOCK: m.action = ACT_BLOCK;
            KEY_P1_UP:    begin m.player = 1'b1; m.action = ACT_UP;    end
            KEY_P1_DOWN:  begin m.player = 1'b1; m.action = ACT_DOWN;  end
            KEY_P1_LEFT:  begin m.player = 1'b1; m.action = ACT_LEFT;  end
            KEY_P1_RIGHT: begin m.player = 1'b1; m.action = ACT_RIGHT; end
            KEY_P1_PUNCH: begin m.player = 1'b1; m.action = ACT_PUNCH; end
            KEY_P1_KICK:  begin m.player = 1'b1; m.action = ACT_KICK;  end
            KEY_P1_BLOCK: begin m.player = 1'b1; m.action = ACT_BLOCK; end
            default:      m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/kc_event_fifo.sv
// First-word fall-through event FIFO with a 5-bit payload.
// When empty, rdata keeps showing the most recently popped entry.
module kc_event_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [4:0]             wdata,
    output logic [4:0]             rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][4:0] mem_q, mem_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [4:0]            last_q, last_d;
    logic                  push_ok, pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = empty ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop && !empty;
        // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
        push_ok  = push && (!full || pop_ok);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
        end
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        last_d   = pop_ok ? mem_q[rd_ptr_q] : last_q;
    end

    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: rtl/keycode_event_scheduler.sv
// Per-frame scan of the four HID keycode slots against the previous frame,
// emitting ordered press/release events for each player into an event FIFO.
module keycode_event_scheduler
    import kc_sched_pkg::*;
#(
    parameter int         DEPTH      = 8,
    parameter logic [2:0] FIGHT_MODE = 3'd2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [7:0]             keycode0,
    input  logic [7:0]             keycode1,
    input  logic [7:0]             keycode2,
    input  logic [7:0]             keycode3,
    input  logic [2:0]             game_mode,
    input  logic                   frame_tick,
    input  logic                   ev_ready,
    input  logic                   ovf_clr,
    output logic                   ev_valid,
    output logic                   ev_player,
    output logic [2:0]             ev_action,
    output logic                   ev_press,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic                   busy
);
    state_t          state_q, state_d;
    logic [2:0]      step_q, step_d;
    logic [3:0][7:0] cur_q, cur_d, prev_q, prev_d;
    logic            overflow_q, overflow_d;

    logic [3:0][7:0] same_set, other_set;
    logic [7:0]      cand;
    map_t            cand_map;
    logic            seen, push, pop, drop, fifo_full, fifo_empty;
    logic [4:0]      push_ev, head_ev;

    // Steps 0-3 look at cur as presses, steps 4-7 look at prev as releases.
    always_comb begin
        same_set  = step_q[2] ? prev_q : cur_q;
        other_set = step_q[2] ? cur_q : prev_q;
        cand      = same_set[step_q[1:0]];
        cand_map  = lookup(cand);
        seen      = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (other_set[j] == cand) seen = 1'b1;
            if ((2'(j) < step_q[1:0]) && (same_set[j] == cand)) seen = 1'b1;
        end
        push    = (state_q == ST_SCAN) && (cand != 8'h00) && !seen && cand_map.hit
                  && (game_mode == FIGHT_MODE);
        push_ev = {cand_map.player, cand_map.action, ~step_q[2]};
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cur_d   = cur_q;
        prev_d  = prev_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    cur_d   = {keycode3, keycode2, keycode1, keycode0};
                    step_d  = 3'd0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                prev_d  = cur_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop  = ev_valid && ev_ready;
    assign drop = push && fifo_full && !pop;

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) overflow_d = 1'b0;
        if (drop)    overflow_d = 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            step_q     <= 3'd0;
            cur_q      <= '0;
            prev_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cur_q      <= cur_d;
            prev_q     <= prev_d;
            overflow_q <= overflow_d;
        end
    end

    kc_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .wdata (push_ev),
        .rdata (head_ev),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ev_valid                         = !fifo_empty;
    assign {ev_player, ev_action, ev_press} = head_ev;
    assign overflow                         = overflow_q;
    assign busy                             = (state_q != ST_IDLE);

endmodule

// File: doc/keycode_event_scheduler.md
Name: keycode_event_scheduler

Overview:
Sequences the four USB HID keycode slots exported by the Nios II SoC into an ordered stream of per-player press/release action events for the fighter logic. On each frame tick it snapshots the slots, scans them against the previous frame's snapshot, and maps recognised keys to a player and an action. It queues the resulting events in a small FIFO drained by the game-state FSM through a valid/ready handshake. Events are only enqueued while the SoC-driven game mode equals the fight mode.

Parameters:
DEPTH, 8, event FIFO entries (power of two, at least 2)
FIGHT_MODE, 3'd2, game_mode value in which events are enqueued

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
keycode0  in  8  HID slot 0 from SoC
keycode1  in  8  HID slot 1
keycode2  in  8  HID slot 2
keycode3  in  8  HID slot 3
game_mode  in  3  current game mode from SoC
frame_tick  in  1  one-cycle pulse at frame start (vsync)
ev_ready  in  1  consumer accepts the head event
ovf_clr  in  1  clears the overflow flag
ev_valid  out  1  FIFO is non-empty
ev_player  out  1  head event player (0 or 1)
ev_action  out  3  head event action code
ev_press  out  1  1 = press, 0 = release
fifo_count  out  $clog2(DEPTH)+1  occupancy
overflow  out  1  sticky; set when an event is dropped
busy  out  1  high in SCAN and COMMIT

Behaviour:
- Reset (async, active-high): state=IDLE; cur[0..3]=0; prev[0..3]=0; FIFO empty; ev_valid=0; ev_player=0; ev_action=0; ev_press=0; fifo_count=0; overflow=0; busy=0.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE: when frame_tick=1, latch keycode0..3 into cur[0..3], clear step to 0, go to SCAN.
- SCAN: runs 8 cycles, step 0..7, one candidate per cycle.
  - Steps 0-3 test cur[step] as a press. Candidate is valid when: code != 0; code is absent from prev[0..3]; code does not appear in any cur[j] with j < step; code is in the keymap.
  - Steps 4-7 test prev[step-4] as a release. Same rules with the roles of cur and prev swapped.
  - A valid candidate pushes {player, action, press} when game_mode == FIGHT_MODE, sampled on the push cycle.
  - After step 7, go to COMMIT.
- COMMIT: one cycle; prev <= cur; go to IDLE.
- frame_tick asserted during SCAN or COMMIT is ignored.
- Timing: for frame_tick at cycle T, SCAN occupies T+1..T+8, COMMIT is T+9, and IDLE is re-entered at T+10. A push in cycle c makes ev_valid visible at c+1, so the earliest ev_valid is T+2.
- Keymap, player 0: W=0x1A up, S=0x16 down, A=0x04 left, D=0x07 right, F=0x09 punch, G=0x0A kick, H=0x0B block.
- Keymap, player 1: 0x52 up, 0x51 down, 0x50 left, 0x4F right, K=0x0E punch, L=0x0F kick, ;=0x33 block.
- Action codes: 0 up, 1 down, 2 left, 3 right, 4 punch, 5 kick, 6 block. Code 7 is never produced. Unmapped codes are ignored.
- FIFO:
  - First-word fall-through; ev_* always show the head entry.
  - Pop when ev_valid && ev_ready.
  - Push and pop in the same cycle are allowed, including when full: the pop frees the slot and the push succeeds, count unchanged.
  - Push when full with no pop: the event is dropped and overflow is set.
  - When empty, ev_valid=0 and ev_* hold their last values.
  - Read and write pointers wrap modulo DEPTH.
- overflow: cleared by ovf_clr. If a set and a clear occur in the same cycle, set wins.
- Events are enqueued in scan order: presses in slot order, then releases in slot order.
- A reset mid-SCAN discards partial progress; the first frame after reset treats every held key as a new press.

Decomposition:
- Shared package kc_sched_pkg:
  - action_t enum (3 bits) and state_t enum
  - keymap constants (14 entries, code to {player, action})
  - a constant function lookup(code) returning {hit, player, action}
- Sub-module kc_event_fifo: parameterised DEPTH, 5-bit payload, FWFT, push/pop/count/full/empty.
- The top level holds the FSM, snapshots and compare logic.

Test Plan:
- Reset; game_mode=2; keycode0=0x1A; frame_tick at T -> at T+2, ev_valid=1, player=0, action=0, press=1; fifo_count=1; busy high T+1..T+9.
- Hold 0x1A; next frame set keycode0=0, keycode1=0x0E -> exactly two events in order: {1,4,press}, then {0,0,release}.
- keycode0=0x09 and keycode2=0x09 (duplicate), plus keycode3=0x2C (unmapped) -> exactly one event {0,4,press}.
- game_mode=0; press 0x04 and tick; then game_mode=2 and tick with the key still held -> no events either frame; releasing later produces {0,2,release}.
- DEPTH=8, ev_ready=0; over 3 frames produce 9 new presses -> fifo_count=8, overflow=1; then ev_ready=1 drains the first 8 in order; ovf_clr clears overflow.
- Assert Reset in SCAN step 3 -> all outputs are at reset values immediately; the next frame re-reports held keys as presses.
